fir_coef_loader: RTL and testbench

- Upstream companion to the FIR tap chain.
- Accepts a stream of coefficients over a valid/ready handshake and collects them in a shadow bank.
- Commits the shadow bank atomically to an active bank on a sample-enable boundary.
- The active bank drives iv_weight of every tap in parallel, so a filter never runs on a partially updated coefficient set.

---
 rtl/fir_coef_loader_pkg.sv | 19 +
 rtl/fir_coef_bank.sv | 65 ++++++
 rtl/fir_coef_loader.sv | 136 +++++++++++++
 tb/tb_fir_coef_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coef_loader_pkg.sv
// rtl/fir_coef_loader_pkg.sv - shared state encodings and default sizes for the coefficient loader
// Defaults match the FIR tap chain so both sides agree on coefficient format.

package fir_coef_loader_pkg;

   // Loader states; encodings are fixed so debug probes and the tap chain agree.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_PEND  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   // Default coefficient width (signed Q1.23) and tap count shared with the tap chain.
   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_NUM_TAPS   = 16;
   localparam int DEF_IDX_WIDTH  = 4;

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - shadow/active coefficient register banks with atomic commit
// Optional feature macro: FIR_COEF_READBACK_EN (registered readback port on the active bank).

module fir_coef_bank #(
   parameter int DATA_WIDTH = 24,
   parameter int NUM_TAPS   = 16,
   parameter int IDX_WIDTH  = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           wr_en,
   input  logic [IDX_WIDTH-1:0]           wr_idx,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   input  logic                           commit,
`ifdef FIR_COEF_READBACK_EN
   input  logic [IDX_WIDTH-1:0]           rd_idx,
   output logic [DATA_WIDTH-1:0]          rd_data,
`endif
   output logic [NUM_TAPS*DATA_WIDTH-1:0] weights
);

   logic [DATA_WIDTH-1:0] shadow [NUM_TAPS];
   logic [DATA_WIDTH-1:0] active [NUM_TAPS];

   // Shadow bank collects incoming beats; the index is compared per tap so an
   // index outside the bank simply writes nothing.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_TAPS; k++) shadow[k] <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            if (wr_idx == IDX_WIDTH'(k)) shadow[k] <= wr_data;
         end
      end
   end

   // Active bank takes the whole shadow bank in one edge so taps never see a mixed set.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_TAPS; k++) active[k] <= '0;
      end else if (commit) begin
         for (int k = 0; k < NUM_TAPS; k++) active[k] <= shadow[k];
      end
   end

   // Flatten the active bank: tap k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_flat
      assign weights[k*DATA_WIDTH +: DATA_WIDTH] = active[k];
   end

`ifdef FIR_COEF_READBACK_EN
   // Registered readback of the active bank; indices past the last tap read as zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= '0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            if (rd_idx == IDX_WIDTH'(k)) rd_data <= active[k];
         end
      end
   end
`endif

endmodule

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - streams FIR coefficients into a shadow bank and commits them on a sample strobe
// Optional feature macro: FIR_COEF_READBACK_EN (adds iv_rd_idx / ov_rd_data readback).

module fir_coef_loader
   import fir_coef_loader_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_TAPS   = DEF_NUM_TAPS,
   parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_en,
   input  logic                           i_coef_valid,
   output logic                           o_coef_ready,
   input  logic [DATA_WIDTH-1:0]          iv_coef,
   input  logic                           i_coef_last,
   output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
   output logic                           o_busy,
   output logic                           o_swap,
`ifdef FIR_COEF_READBACK_EN
   input  logic [IDX_WIDTH-1:0]           iv_rd_idx,
   output logic [DATA_WIDTH-1:0]          ov_rd_data,
`endif
   output logic                           o_err
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_TAPS - 1);

   state_t               state;
   logic [IDX_WIDTH-1:0] idx;
   logic                 ready;
   logic                 busy;
   logic                 swap;
   logic                 err;

   logic                 accept;
   logic                 loading;
   logic                 wr_en;
   logic                 commit;

   assign accept  = i_coef_valid && ready;
   assign loading = (state == S_IDLE) || (state == S_LOAD);
   assign wr_en   = accept && loading;
   // The strobe only counts once we are already waiting, so an i_en coinciding
   // with the final beat does not commit early.
   assign commit  = (state == S_PEND) && i_en;

   // Frame tracking FSM; ready/busy/swap/err are registered alongside the state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
         idx   <= '0;
         ready <= 1'b1;
         busy  <= 1'b0;
         swap  <= 1'b0;
         err   <= 1'b0;
      end else begin
         swap <= 1'b0;
         case (state)
            S_IDLE, S_LOAD: begin
               if (accept) begin
                  if (i_coef_last) begin
                     idx <= '0;
                     if (idx == LAST_IDX) begin
                        state <= S_PEND;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                     end else begin
                        // Short frame: drop it, keep the active bank as is.
                        err   <= 1'b1;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
                  end else if (idx == LAST_IDX) begin
                     // Long frame: swallow the excess beats until last.
                     err   <= 1'b1;
                     state <= S_DRAIN;
                     busy  <= 1'b1;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_LOAD;
                     busy  <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (accept && i_coef_last) begin
                  state <= S_IDLE;
                  idx   <= '0;
                  busy  <= 1'b0;
               end
            end
            S_PEND: begin
               if (i_en) begin
                  state <= S_IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
                  swap  <= 1'b1;
                  err   <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               idx   <= '0;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_coef_ready = ready;
   assign o_busy       = busy;
   assign o_swap       = swap;
   assign o_err        = err;

   fir_coef_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_TAPS   (NUM_TAPS),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_bank (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .wr_en   (wr_en),
      .wr_idx  (idx),
      .wr_data (iv_coef),
      .commit  (commit),
`ifdef FIR_COEF_READBACK_EN
      .rd_idx  (iv_rd_idx),
      .rd_data (ov_rd_data),
`endif
      .weights (ov_weights)
   );

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - scoreboard bench for the FIR coefficient loader

module tb_fir_coef_loader;

   localparam int DW = 24;
   localparam int NT = 16;
   localparam int IW = 4;
   localparam int WW = DW * NT;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          coef_valid;
   logic          coef_ready;
   logic [DW-1:0] coef;
   logic          coef_last;
   logic [WW-1:0] weights;
   logic          busy;
   logic          swap;
   logic          err;
`ifdef FIR_COEF_READBACK_EN
   logic [IW-1:0] rd_idx;
   logic [DW-1:0] rd_data;
`endif

   int checks = 0;
   int errors = 0;

   logic [WW-1:0] exp_q [$];
   logic [WW-1:0] model = '0;
   logic [DW-1:0] f [NT];

   always #5 clk = ~clk;

   fir_coef_loader #(
      .DATA_WIDTH (DW),
      .NUM_TAPS   (NT),
      .IDX_WIDTH  (IW)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_coef_valid (coef_valid),
      .o_coef_ready (coef_ready),
      .iv_coef      (coef),
      .i_coef_last  (coef_last),
      .ov_weights   (weights),
      .o_busy       (busy),
      .o_swap       (swap),
`ifdef FIR_COEF_READBACK_EN
      .iv_rd_idx    (rd_idx),
      .ov_rd_data   (rd_data),
`endif
      .o_err        (err)
   );

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   // Monitor: a swap pulse pops the next expected bank; the bank is compared every cycle.
   always @(posedge clk) begin : mon
      logic r;
      r = rst;
      #2;
      if (r) model = '0;
      if (swap === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_swap: got swap=1 expected no pending commit");
         end else begin
            model = exp_q.pop_front();
         end
      end
      check("weights", weights, model);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [WW-1:0] pack_f();
      logic [WW-1:0] r;
      for (int k = 0; k < NT; k++) r[k*DW +: DW] = f[k];
      return r;
   endfunction

   task automatic beat(input logic [DW-1:0] d, input logic l);
      int n;
      n = 0;
      coef_valid = 1'b1;
      coef       = d;
      coef_last  = l;
      while (coef_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: got ready=0 for 50 cycles expected ready=1");
      end
      @(negedge clk);
      coef_valid = 1'b0;
      coef_last  = 1'b0;
   endtask

   task automatic send_frame(input int n);
      for (int k = 0; k < n; k++)
         beat((k < NT) ? f[k] : (24'hEE0000 | DW'(k)), k == n - 1);
   endtask

   task automatic commit_exp();
      exp_q.push_back(pack_f());
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check("swap_on", WW'(swap), 1);
      check("err_after_commit", WW'(err), 0);
      @(negedge clk);
      check("swap_off", WW'(swap), 0);
      check("busy_after_commit", WW'(busy), 0);
      check("ready_after_commit", WW'(coef_ready), 1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; coef_valid = 1'b0; coef_last = 1'b0; coef = '0;
`ifdef FIR_COEF_READBACK_EN
      rd_idx = '0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", WW'(coef_ready), 1);
      check("rst_busy", WW'(busy), 0);
      check("rst_swap", WW'(swap), 0);
      check("rst_err", WW'(err), 0);
      check("rst_weights", weights, 0);

      // 1: frame 1..16, commit three cycles after the last beat
      for (int k = 0; k < NT; k++) f[k] = DW'(k + 1);
      send_frame(NT);
      check("pend_busy", WW'(busy), 1);
      check("pend_ready", WW'(coef_ready), 0);
      repeat (3) @(negedge clk);
      check("pend_no_swap", WW'(swap), 0);
      commit_exp();
      check("t1_tap0", WW'(weights[0 +: DW]), 1);
      check("t1_tap15", WW'(weights[15*DW +: DW]), 16);

`ifdef FIR_COEF_READBACK_EN
      rd_idx = 4'd5;
      @(negedge clk);
      check("rd_idx5", WW'(rd_data), 6);
      rd_idx = 4'd15;
      @(negedge clk);
      check("rd_idx15", WW'(rd_data), 16);
`endif

      // PEND entered on an i_en edge: the strobe must not commit
      for (int k = 0; k < NT; k++) f[k] = 24'h800000 | DW'(k);
      for (int k = 0; k < NT - 1; k++) beat(f[k], 1'b0);
      en = 1'b1;
      beat(f[NT-1], 1'b1);
      en = 1'b0;
      check("pre_en_no_swap", WW'(swap), 0);
      check("pre_en_busy", WW'(busy), 1);
      @(negedge clk);
      check("pre_en_no_swap2", WW'(swap), 0);
      commit_exp();

      // 2: short frame, then a good frame clears the error
      for (int k = 0; k < NT; k++) f[k] = DW'(100 + k);
      send_frame(10);
      check("short_err", WW'(err), 1);
      check("short_busy", WW'(busy), 0);
      check("short_ready", WW'(coef_ready), 1);
      repeat (2) @(negedge clk);
      for (int k = 0; k < NT; k++) f[k] = 24'hFFFFFF - DW'(k);
      send_frame(NT);
      check("short_err_held", WW'(err), 1);
      commit_exp();

      // 3: long frame of 20 beats
      for (int k = 0; k < NT; k++) f[k] = 24'h123400 | DW'(k);
      for (int k = 0; k < NT; k++) beat(f[k], 1'b0);
      check("long_err", WW'(err), 1);
      check("long_busy", WW'(busy), 1);
      check("long_ready", WW'(coef_ready), 1);
      for (int k = NT; k < 20; k++) beat(24'hEE0000 | DW'(k), k == 19);
      check("long_busy_done", WW'(busy), 0);
      check("long_err_held", WW'(err), 1);
      repeat (2) @(negedge clk);

      // 4: backpressure in PEND, held beat becomes tap 0 of the next frame
      for (int k = 0; k < NT; k++) f[k] = 24'h5A0000 | DW'(k);
      send_frame(NT);
      coef_valid = 1'b1; coef = 24'h00DEAD; coef_last = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("bp_ready", WW'(coef_ready), 0);
         @(negedge clk);
      end
      exp_q.push_back(pack_f());
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check("bp_swap", WW'(swap), 1);
      check("bp_ready_after", WW'(coef_ready), 1);
      f[0] = 24'h00DEAD;
      for (int k = 1; k < NT; k++) f[k] = 24'h0B0000 | DW'(k);
      for (int k = 0; k < NT; k++) beat(f[k], k == NT - 1);
      commit_exp();
      check("bp_tap0", WW'(weights[0 +: DW]), 24'h00DEAD);

      // 5: reset mid-frame (with the error flag set) and reset in PEND
      send_frame(3);
      check("pre_rst_err", WW'(err), 1);
      for (int k = 0; k < NT; k++) f[k] = 24'h777000 | DW'(k);
      for (int k = 0; k < 6; k++) beat(f[k], 1'b0);
      coef_valid = 1'b1; coef = f[6]; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; coef_valid = 1'b0;
      check("mid_rst_ready", WW'(coef_ready), 1);
      check("mid_rst_busy", WW'(busy), 0);
      check("mid_rst_err", WW'(err), 0);
      check("mid_rst_swap", WW'(swap), 0);
      check("mid_rst_weights", weights, 0);
      send_frame(NT);
      check("pend_rst_busy_pre", WW'(busy), 1);
      en = 1'b1; rst = 1'b1;
      @(negedge clk);
      en = 1'b0; rst = 1'b0;
      check("pend_rst_swap", WW'(swap), 0);
      check("pend_rst_busy", WW'(busy), 0);
      check("pend_rst_ready", WW'(coef_ready), 1);
      check("pend_rst_weights", weights, 0);
      @(negedge clk);
      check("pend_rst_swap2", WW'(swap), 0);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check("idle_en_no_swap", WW'(swap), 0);

      repeat (3) @(negedge clk);
      check("queue_empty", WW'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
